// File: rtl/sort8_rr_scheduler_pkg.sv
// Shared widths and helpers for the two-requester sort8 scheduler.
package sort8_rr_scheduler_pkg;
    localparam int DATA_WIDTH_DEF  = 8;
    localparam int LABEL_WIDTH_DEF = 3;
    localparam int N_ELEM          = 8;
    localparam int OWNER_W         = 1;

    function automatic int vec_w(input int n, input int w);
        return n * w;
    endfunction
endpackage

// File: rtl/sort8_rr_scheduler_if.sv
// Requester job port and result port bundles for the sort8 scheduler.
interface sort8_req_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 3
);
    import sort8_rr_scheduler_pkg::*;
    localparam int XW = vec_w(N_ELEM, DATA_WIDTH);
    localparam int LW = vec_w(N_ELEM, LABEL_WIDTH);

    logic          valid;
    logic          ready;
    logic [XW-1:0] x;
    logic [LW-1:0] x_label;

    modport master (output valid, x, x_label, input ready);
    modport slave  (input valid, x, x_label, output ready);
endinterface

interface sort8_res_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 3
);
    import sort8_rr_scheduler_pkg::*;
    localparam int XW = vec_w(N_ELEM, DATA_WIDTH);
    localparam int LW = vec_w(N_ELEM, LABEL_WIDTH);

    logic          valid;
    logic          ready;
    logic [XW-1:0] y;
    logic [LW-1:0] y_label;
    logic          owner;

    modport master (output valid, y, y_label, owner, input ready);
    modport slave  (input valid, y, y_label, owner, output ready);
endinterface

// File: rtl/sort8_result_fifo.sv
// Synchronous FIFO, power-of-two depth, used for results and for owner tags.
module sort8_result_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_wr, do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/sort8_rr_scheduler.sv
// Round-robin sharing of one fire-and-forget 8-input sorter between two
// requesters; credits bound in-flight + buffered jobs so results never stall.
module sort8_rr_scheduler
    import sort8_rr_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int LABEL_WIDTH = LABEL_WIDTH_DEF,
    parameter int OUT_DEPTH   = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    sort8_req_if.slave                              r0,
    sort8_req_if.slave                              r1,
    output logic                                    s_x_valid,
    output logic [vec_w(N_ELEM, DATA_WIDTH)-1:0]    s_x,
    output logic [vec_w(N_ELEM, LABEL_WIDTH)-1:0]   s_x_label,
    input  logic                                    s_y_valid,
    input  logic [vec_w(N_ELEM, DATA_WIDTH)-1:0]    s_y,
    input  logic [vec_w(N_ELEM, LABEL_WIDTH)-1:0]   s_y_label,
    sort8_res_if.master                             m,
    output logic                                    err_overflow
);
    localparam int XW = vec_w(N_ELEM, DATA_WIDTH);
    localparam int LW = vec_w(N_ELEM, LABEL_WIDTH);
    localparam int RW = XW + LW + OWNER_W;
    localparam int CW = $clog2(OUT_DEPTH) + 1;

    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          avail, grant_vld, grant_idx, issue, pop;
    logic          oq_owner, oq_empty, oq_full;
    logic          rf_empty, rf_full;
    logic [RW-1:0] rf_rd_data;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (r0.valid && r1.valid) begin
            grant_vld = 1'b1;
            grant_idx = ~last_grant;
        end else if (r0.valid) begin
            grant_vld = 1'b1;
        end else if (r1.valid) begin
            grant_vld = 1'b1;
            grant_idx = 1'b1;
        end
    end

    // Credit uses the registered count, so a pop frees a slot one cycle later.
    assign avail    = (cnt < CW'(OUT_DEPTH)) && !oq_full;
    assign issue    = avail && grant_vld;
    assign r0.ready = issue && !grant_idx;
    assign r1.ready = issue && grant_idx;

    assign m.valid = !rf_empty;
    assign pop     = m.valid && m.ready;
    assign {m.y, m.y_label, m.owner} = rf_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_x_valid    <= 1'b0;
            s_x          <= '0;
            s_x_label    <= '0;
            last_grant   <= 1'b1;
            cnt          <= '0;
            err_overflow <= 1'b0;
        end else begin
            s_x_valid <= issue;
            if (issue) begin
                s_x        <= grant_idx ? r1.x : r0.x;
                s_x_label  <= grant_idx ? r1.x_label : r0.x_label;
                last_grant <= grant_idx;
            end
            case ({issue, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase
            if (s_y_valid && (oq_empty || (rf_full && !pop))) err_overflow <= 1'b1;
        end
    end

    // Sorter returns in issue order, so a FIFO of owner bits tags each result.
    sort8_result_fifo #(.WIDTH(OWNER_W), .DEPTH(OUT_DEPTH)) u_owner_q (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (issue),
        .wr_data (grant_idx),
        .rd_en   (s_y_valid),
        .rd_data (oq_owner),
        .empty   (oq_empty),
        .full    (oq_full)
    );

    sort8_result_fifo #(.WIDTH(RW), .DEPTH(OUT_DEPTH)) u_result_q (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s_y_valid && !oq_empty),
        .wr_data ({s_y, s_y_label, oq_owner}),
        .rd_en   (pop),
        .rd_data (rf_rd_data),
        .empty   (rf_empty),
        .full    (rf_full)
    );
endmodule

// File: tb/tb_sort8_rr_scheduler.sv
// Scoreboard bench for sort8_rr_scheduler with a 2-register ascending sorter model.
module tb_sort8_rr_scheduler;
    localparam int DW = 8, LBW = 3, XW = 64, LW = 24, DEPTH = 4;

    localparam logic [XW-1:0] TV_X [4] = '{64'h0706050400010203, 64'h050f1923281e140a,
                                            64'h01323cfac8640908, 64'hccddeeff33221100};
    localparam logic [XW-1:0] TV_Y [4] = '{64'h0706050403020100, 64'h28231e19140f0a05,
                                            64'hfac8643c32090801, 64'hffeeddcc33221100};
    localparam logic [LW-1:0] TV_YL [4] = '{24'o76540123, 24'o34251607, 24'o43256107, 24'o45673210};
    localparam logic [LW-1:0] LBL_IN = 24'o76543210;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    sort8_req_if #(.DATA_WIDTH(DW), .LABEL_WIDTH(LBW)) r0_if ();
    sort8_req_if #(.DATA_WIDTH(DW), .LABEL_WIDTH(LBW)) r1_if ();
    sort8_res_if #(.DATA_WIDTH(DW), .LABEL_WIDTH(LBW)) m_if ();

    logic          s_x_valid, s_y_valid, err_overflow;
    logic [XW-1:0] s_x, s_y;
    logic [LW-1:0] s_x_label, s_y_label;

    sort8_rr_scheduler #(.DATA_WIDTH(DW), .LABEL_WIDTH(LBW), .OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .r0(r0_if), .r1(r1_if),
        .s_x_valid(s_x_valid), .s_x(s_x), .s_x_label(s_x_label),
        .s_y_valid(s_y_valid), .s_y(s_y), .s_y_label(s_y_label),
        .m(m_if), .err_overflow(err_overflow)
    );

    // Sorter model: element 0 smallest, labels follow their data.
    function automatic logic [XW+LW-1:0] sort_model(input logic [XW-1:0] x, input logic [LW-1:0] l);
        logic [DW-1:0] e [8];
        logic [LBW-1:0] t [8];
        logic [DW-1:0] te;
        logic [LBW-1:0] tl;
        logic [XW-1:0] y;
        logic [LW-1:0] yl;
        for (int i = 0; i < 8; i++) begin e[i] = x[i*DW +: DW]; t[i] = l[i*LBW +: LBW]; end
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7 - i; j++)
                if (e[j] > e[j+1]) begin
                    te = e[j]; e[j] = e[j+1]; e[j+1] = te;
                    tl = t[j]; t[j] = t[j+1]; t[j+1] = tl;
                end
        for (int i = 0; i < 8; i++) begin y[i*DW +: DW] = e[i]; yl[i*LBW +: LBW] = t[i]; end
        return {yl, y};
    endfunction

    logic [1:0]       pv = 2'b00;
    logic [XW+LW-1:0] pd [2];
    logic             inj = 1'b0;
    always @(posedge clk) begin
        pv    <= {pv[0], s_x_valid};
        pd[0] <= sort_model(s_x, s_x_label);
        pd[1] <= pd[0];
    end
    assign s_y_valid = pv[1] | inj;
    assign {s_y_label, s_y} = pd[1];

    int n_vec = 0, n_err = 0;
    logic [88:0] exp_q [$];
    bit grant_q [$];
    int rem0 = 0, rem1 = 0, idx0 = 0, idx1 = 0, acc0 = 0, acc1 = 0;
    bit hs0 = 1'b0, hs1 = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting, expected completion", nm);
    endtask

    // Requester driver: handshakes are sampled once inputs settle, booked next negedge.
    initial forever begin
        @(negedge clk);
        if (rst && hs0) begin
            exp_q.push_back({1'b0, TV_YL[idx0%4], TV_Y[idx0%4]});
            grant_q.push_back(1'b0);
            idx0++; rem0--; acc0++;
        end
        if (rst && hs1) begin
            exp_q.push_back({1'b1, TV_YL[(idx1+2)%4], TV_Y[(idx1+2)%4]});
            grant_q.push_back(1'b1);
            idx1++; rem1--; acc1++;
        end
        r0_if.valid = rem0 > 0; r0_if.x = TV_X[idx0%4];     r0_if.x_label = LBL_IN;
        r1_if.valid = rem1 > 0; r1_if.x = TV_X[(idx1+2)%4]; r1_if.x_label = LBL_IN;
        #1;
        hs0 = rst && r0_if.valid && r0_if.ready;
        hs1 = rst && r1_if.valid && r1_if.ready;
    end

    // Monitor: compares each popped result and checks the head holds under backpressure.
    logic [88:0] prev_d;
    bit prev_hold = 1'b0;
    initial forever begin
        logic [88:0] e, cur;
        @(negedge clk);
        #4;
        cur = {m_if.owner, m_if.y_label, m_if.y};
        if (!rst) prev_hold = 1'b0;
        else begin
            if (prev_hold && m_if.valid) chk("hold_stable", cur, prev_d);
            if (m_if.valid && m_if.ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_result: got %0h expected no output", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_y", m_if.y, e[63:0]);
                    chk("m_y_label", m_if.y_label, e[87:64]);
                    chk("m_owner", m_if.owner, e[88]);
                end
            end
            prev_hold = m_if.valid && !m_if.ready;
            prev_d = cur;
        end
    end

    task automatic tk();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rem0 = 0; rem1 = 0; m_if.ready = 1'b0; inj = 1'b0;
        tk();
        rst = 1'b0;
        #1;
        exp_q.delete(); grant_q.delete();
        idx0 = 0; idx1 = 0; acc0 = 0; acc1 = 0; hs0 = 1'b0; hs1 = 1'b0;
        tk(); tk();
        rst = 1'b1;
        tk();
    endtask

    task automatic wait_jobs(input int n0, input int n1, input int budget);
        int c = 0;
        while ((acc0 < n0 || acc1 < n1) && c < budget) begin tk(); c++; end
        if (acc0 < n0 || acc1 < n1) fail_to("wait_jobs");
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        m_if.ready = 1'b1;
        while ((exp_q.size() != 0 || m_if.valid || pv != 0) && c < budget) begin tk(); c++; end
        if (exp_q.size() != 0 || m_if.valid) fail_to("wait_drain");
    endtask

    initial begin
        int lat;
        r0_if.valid = 1'b0; r1_if.valid = 1'b0; m_if.ready = 1'b0;
        r0_if.x = '0; r1_if.x = '0; r0_if.x_label = '0; r1_if.x_label = '0;

        // Reset state
        tk();
        chk("rst_m_valid", m_if.valid, 0);
        chk("rst_s_x_valid", s_x_valid, 0);
        chk("rst_s_x", s_x, 0);
        chk("rst_s_x_label", s_x_label, 0);
        chk("rst_err", err_overflow, 0);
        chk("rst_r0_ready", r0_if.ready, 0);
        chk("rst_r1_ready", r1_if.ready, 0);
        rst = 1'b1;
        tk();

        // Single job: strobe timing and latency to m_valid
        m_if.ready = 1'b1;
        rem0 = 1;
        wait_jobs(1, 0, 20);
        chk("single_s_x_valid", s_x_valid, 1);
        chk("single_s_x", s_x, TV_X[0]);
        chk("single_s_x_label", s_x_label, LBL_IN);
        tk();
        chk("single_s_x_valid_1cyc", s_x_valid, 0);
        lat = 1;
        while (!m_if.valid && lat < 20) begin tk(); lat++; end
        chk("single_latency", lat, 3);
        wait_drain(50);

        // Contention: alternate grants, r0 first after reset
        do_reset();
        m_if.ready = 1'b1;
        rem0 = 6; rem1 = 6;
        wait_jobs(6, 6, 100);
        wait_drain(100);
        chk("grant_count", grant_q.size(), 12);
        for (int i = 0; i < 12 && i < grant_q.size(); i++) chk("grant_order", grant_q[i], i % 2);

        // Backpressure: credits stop r0 at 4; one pop frees exactly one slot a cycle later
        do_reset();
        rem0 = 100;
        repeat (15) tk();
        chk("bp_accepts", acc0, 4);
        chk("bp_ready_full", r0_if.ready, 0);
        m_if.ready = 1'b1;
        chk("bp_ready_same_cycle", r0_if.ready, 0);
        tk();
        m_if.ready = 1'b0;
        chk("bp_ready_after_pop", r0_if.ready, 1);
        tk();
        chk("bp_one_more", acc0, 5);
        chk("bp_ready_again_full", r0_if.ready, 0);
        repeat (10) tk();
        chk("bp_accepts_final", acc0, 5);
        rem0 = 0;
        wait_drain(100);
        chk("bp_err", err_overflow, 0);

        // Issue and pop in the same cycle at cnt=3
        do_reset();
        rem0 = 3;
        wait_jobs(3, 0, 20);
        repeat (8) tk();
        rem0 = 1;
        tk();
        m_if.ready = 1'b1;
        chk("sim_ready_cnt3", r0_if.ready, 1);
        tk();
        m_if.ready = 1'b0;
        chk("sim_accepted", acc0, 4);
        rem0 = 5;
        repeat (10) tk();
        chk("sim_cnt_held", acc0, 5);
        chk("sim_ready_full", r0_if.ready, 0);
        rem0 = 0;
        wait_drain(100);
        chk("sim_err", err_overflow, 0);

        // Mixed traffic with an irregular m_ready pattern
        do_reset();
        rem0 = 5; rem1 = 5;
        for (int c = 0; c < 200 && (acc0 < 5 || acc1 < 5 || exp_q.size() != 0); c++) begin
            m_if.ready = (c % 3) != 0;
            tk();
        end
        wait_drain(100);
        chk("mix_accepts", acc0 + acc1, 10);
        chk("mix_err", err_overflow, 0);

        // Reset mid-flight: 1 buffered, 2 in the sorter
        do_reset();
        rem0 = 3;
        lat = 0;
        while (!m_if.valid && lat < 20) begin tk(); lat++; end
        if (!m_if.valid) fail_to("midrst_first_result");
        rst = 1'b0;
        #1;
        chk("midrst_m_valid_async", m_if.valid, 0);
        chk("midrst_s_x_valid_async", s_x_valid, 0);
        exp_q.delete(); grant_q.delete();
        rem0 = 0; idx0 = 0; acc0 = 0; hs0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) tk();
        chk("midrst_stale_err", err_overflow, 1);
        chk("midrst_m_valid", m_if.valid, 0);
        do_reset();
        chk("midrst_err_cleared", err_overflow, 0);

        // Spurious result with nothing issued; flag is sticky
        inj = 1'b1;
        tk();
        inj = 1'b0;
        tk();
        chk("spur_err", err_overflow, 1);
        chk("spur_m_valid", m_if.valid, 0);
        m_if.ready = 1'b1;
        rem0 = 2; rem1 = 2;
        wait_jobs(2, 2, 50);
        wait_drain(100);
        chk("spur_err_sticky", err_overflow, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sort8_rr_scheduler.md
Name: sort8_rr_scheduler

Overview:
- Shares one 8-input bitonic merge sorter between two requesters.
- Performs round-robin arbitration on valid/ready request ports and drives the sorter's fire-and-forget input (x_valid, no backpressure).
- Tags every issued job with its owner and buffers sorter results in an output FIFO behind a valid/ready port.
- A credit counter guarantees the FIFO can never overflow, so the sorter never needs to stall.

Parameters:
- DATA_WIDTH, 8, width of one element.
- LABEL_WIDTH, 3, width of one element label.
- OUT_DEPTH, 4, result FIFO depth and maximum jobs in flight plus buffered; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- r0_valid  in  1  requester 0 has a job.
- r0_ready  out  1  requester 0 job accepted this cycle when r0_valid & r0_ready.
- r0_x  in  DATA_WIDTH*8  8 elements, element i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- r0_x_label  in  LABEL_WIDTH*8  labels, same packing.
- r1_valid, r1_ready, r1_x, r1_x_label  same as requester 0.
- s_x_valid  out  1  job strobe to sorter.
- s_x  out  DATA_WIDTH*8  sorter data input.
- s_x_label  out  LABEL_WIDTH*8  sorter label input.
- s_y_valid  in  1  sorter result strobe.
- s_y  in  DATA_WIDTH*8  sorter result data.
- s_y_label  in  LABEL_WIDTH*8  sorter result labels.
- m_valid  out  1  result available.
- m_ready  in  1  consumer accepts result.
- m_y  out  DATA_WIDTH*8  result data.
- m_y_label  out  LABEL_WIDTH*8  result labels.
- m_owner  out  1  requester index (0/1) that owns m_y.
- err_overflow  out  1  sticky: s_y_valid arrived while FIFO full, or with the owner queue empty.

Behaviour:
- Reset (rst=0, async): r0_ready=r1_ready=0, s_x_valid=0, s_x=0, s_x_label=0, m_valid=0, err_overflow=0, credit count=0, FIFO and owner queue empty, last_grant=1 (so requester 0 wins the first tie). Reset mid-operation discards all in-flight and buffered jobs. Sorter results arriving after reset release are ignored: the owner queue is empty, err_overflow sets.
- Credit: cnt = jobs issued but not yet popped at m (in sorter + in FIFO); range 0..OUT_DEPTH. avail = (cnt < OUT_DEPTH).
- Arbitration (combinational, when avail):
  - both valid: grant the requester != last_grant.
  - one valid: grant it.
  - none: no grant.
  - rN_ready = avail & (grant==N). rN_ready may depend on rN_valid and on the other requester's valid.
  - last_grant updates only on an accepted handshake.
- Issue: on handshake, register the granted x/x_label into s_x/s_x_label; s_x_valid=1 the next cycle, for exactly one cycle. At most one issue per cycle; back-to-back issues allowed. Push the owner bit into the owner queue (depth OUT_DEPTH) in the handshake cycle.
- Ordering: sorter latency is fixed and results come back in issue order. On s_y_valid, pop the owner queue and write {s_y, s_y_label, owner} into the result FIFO in the same cycle.
- Output: m_valid = FIFO not empty; m_y/m_y_label/m_owner show the FIFO head. Pop on m_valid & m_ready. Outputs hold stable while m_valid & !m_ready.
- cnt update: +1 on issue, -1 on pop; both in one cycle: unchanged. Full credit (cnt==OUT_DEPTH): both readies 0 until a pop. A pop in a cycle does not raise ready in that same cycle (ready uses registered cnt).
- Simultaneous FIFO write and pop: allowed, at any occupancy including full (write and pop both succeed).
- Pointers wrap modulo OUT_DEPTH.
- Error: err_overflow sets on s_y_valid when the FIFO is full without a simultaneous pop, or when the owner queue is empty. The offending result is dropped; the flag clears only on reset.
- No content checking: the scheduler passes the 8 elements unchanged. Requesters must present the first 4 elements sorted in the sorter's direction and the last 4 sorted in the opposite direction.

Decomposition:
- Shared package: element/label width defaults, the packed-vector width helper (N*WIDTH), and the owner-index width constant.
- One natural sub-module: sort8_result_fifo, a synchronous FIFO (parameterized width, depth, async active-low rst) used for the result FIFO (width DATA_WIDTH*8+LABEL_WIDTH*8+1). The owner queue is a second instance of it, 1 bit wide.
- The sorter itself stays outside the block and is wired by the parent.

Test Plan:
- Single job: r0 presents x={7,6,5,4,0,1,2,3} (element 7 first) with a sorter model of latency 3, m_ready=1 → s_x_valid one cycle after the handshake; m_valid 3 cycles later; m_owner=0, labels permuted consistently with the data.
- Contention: r0_valid=r1_valid=1 held for 6 jobs each, m_ready=1 → grants alternate 0,1,0,1…; r0 is granted first after reset; m_owner sequence alternates.
- Backpressure: m_ready=0, OUT_DEPTH=4, r0 streaming → exactly 4 accepts, then r0_ready=0; raising m_ready for one cycle → one pop, and exactly one further accept the following cycle.
- Issue and pop in the same cycle at cnt=3 → cnt stays 3; FIFO write and pop in the same cycle at full FIFO → no error; data order preserved.
- Reset mid-flight: assert rst=0 with 2 jobs in the sorter and 1 buffered → m_valid=0 immediately (async). A stale s_y_valid after release → err_overflow=1, m_valid stays 0.
- Spurious result: s_y_valid pulse with no job issued → err_overflow=1 and stays 1 through later normal traffic.
